// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port architectural register file.
// One write port, NUM_RD independent combinational read ports, a hardware
// clear sequencer that zeroes every entry after reset, an optional
// write-to-read bypass and an optional hardwired-zero register 0.

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     write_enable_i,
  input  logic [ADDR_W-1:0]        write_addr_i,
  input  logic [DATA_W-1:0]        write_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] read_addr_i,
  output logic [NUM_RD*DATA_W-1:0] read_data_o,
  output logic                     ready_o
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] rf_q [DEPTH];

  logic in_clear;
  logic write_accept;

  // A write to entry 0 is discarded when it is hardwired to zero, and no
  // write is taken until the clear sequence has finished.
  assign in_clear     = (state_q == ST_CLEAR);
  assign write_accept = write_enable_i && !in_clear &&
                        !((ZERO_REG != 0) && (write_addr_i == '0));
  assign ready_o      = (state_q == ST_READY);

  // Clear sequencer: walk clr_ptr over every entry, finish on the last address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else if (in_clear) begin
      clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == LAST_ADDR) begin
        state_q <= ST_READY;
      end
    end
  end

  // Storage: the sequencer owns the array while clearing, the write port afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (in_clear) begin
        rf_q[clr_ptr_q] <= '0;
      end else if (write_accept) begin
        rf_q[write_addr_i] <= write_data_i;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = read_addr_i[p*ADDR_W +: ADDR_W];

    // Read mux: clear masks everything, then zero register, then bypass, then storage.
    always_comb begin
      rd_data = rf_q[rd_addr];
      if (in_clear) begin
        rd_data = '0;
      end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_data = '0;
      end else if ((BYPASS != 0) && write_accept && (rd_addr == write_addr_i)) begin
        rd_data = write_data_i;
      end
    end

    assign read_data_o[p*DATA_W +: DATA_W] = rd_data;
  end

endmodule
